vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-rate VGA 640x480@60 timing generator driving the colour/sync output stage. Divides the 100 MHz system clock into a pixel-enable strobe, runs the horizontal and vertical counters, and emits registered sync, active-video, and pixel-coordinate signals. The downstream colour logic consumes only these outputs and needs no counter decode of its own.

## Interface
- CLK_DIV, 4, system clocks per pixel (≥1)
- H_SYNC, 96; H_BP, 48; H_ACTIVE, 640; H_FP, 16, horizontal segment lengths in pixels
- V_SYNC, 2; V_BP, 33; V_ACTIVE, 480; V_FP, 10, vertical segment lengths in lines
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous, active-low reset
- pix_en  out  1  one-clk strobe, once per pixel period
- h_count  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- v_count  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- hsync  out  1  low while h_count < H_SYNC
- vsync  out  1  low while v_count < V_SYNC
- active  out  1  high inside the visible 640x480 window
- x  out  10  h_count-(H_SYNC+H_BP) when active, else 0
- y  out  10  v_count-(V_SYNC+V_BP) when active, else 0
- line_start  out  1  one-clk pulse after each h wrap
- frame_start  out  1  one-clk pulse after each (h,v) wrap to (0,0)

## Operation
- One clock; reset is synchronous and active-low. All state updates on the rising edge of clk.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV = 1, pix_en is constantly high after reset.
- On an edge with pix_en high:
  - h_count increments.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - v_count wraps to 0 at V_TOTAL-1 when h_count also wraps.
- When pix_en is low, counters and all decoded outputs hold.
- hsync, vsync, active, x, and y are registered. They are computed from the next-state counter values, so they always match the h_count/v_count presented in the same cycle, with zero skew.
- Active window: h_count in [144, 783] and v_count in [35, 514], inclusive for the defaults.
- Sync polarity is negative for both hsync and vsync.
- line_start is high for exactly the one clk following the edge where h_count wrapped to 0. frame_start is high for the one clk following the edge where both counters wrapped. Neither pulses on reset release.
- Arithmetic is unsigned, 10-bit. Elaboration must fail if H_TOTAL > 1024 or V_TOTAL > 1024.

## Timing
- Reset values: div_cnt = 0, h_count = 0, v_count = 0, pix_en = 0, hsync = 0, vsync = 0, active = 0, x = 0, y = 0, line_start = 0, frame_start = 0.
- First pix_en occurs CLK_DIV clks after rst_n deasserts (sampled high).
- Pixel period is CLK_DIV clks; line period is 800·CLK_DIV clks; frame period is 525·800·CLK_DIV clks (1,680,000 at default).
- A reset asserted mid-frame takes effect on the next edge regardless of pix_en. Counting restarts from (0,0) with no partial pulses.
- Simultaneous h and v wrap: line_start and frame_start both pulse in the same clk.

## Structure
- Package vga_timing_pkg holds:
  - default segment constants
  - derived H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START
  - counter width localparam (10)
- Sub-module vga_pix_tick holds the CLK_DIV divider and produces pix_en. Counters and decode stay in vga_timing_gen.

## Test plan
- Reset held 10 clks, then released: every output equals its reset value during reset; first pix_en arrives at clk 4 after release; pix_en period is 4.
- Horizontal: hsync low for exactly 384 clks per line, line period 3200 clks; x = 0 at h_count = 144, x = 639 at h_count = 783; active drops at h_count = 784.
- Vertical: vsync low for exactly 6400 clks (2 lines); y = 0 at v_count = 35, y = 479 at v_count = 514; frame period 1,680,000 clks.
- Count pix_en cycles with active high over one frame: 307,200. x and y are 0 whenever active is low.
- Wrap at (799,524): next values are (0,0), and line_start and frame_start pulse together for 1 clk; at (799,10) only line_start pulses.
- Assert rst_n low mid-frame at (400,200) for 1 clk: next cycle shows all reset values; the full sequence then repeats as in the first scenario.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared constants and types for the VGA timing generator
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  // 640x480@60 from a 100 MHz system clock
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    cnt_t x;
    cnt_t y;
  } vga_decode_t;

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - timing bundle from the generator to the colour/sync stage
interface vga_timing_if;

  logic                            pix_en;
  logic [vga_timing_pkg::CNT_W-1:0] h_count;
  logic [vga_timing_pkg::CNT_W-1:0] v_count;
  logic                            hsync;
  logic                            vsync;
  logic                            active;
  logic [vga_timing_pkg::CNT_W-1:0] x;
  logic [vga_timing_pkg::CNT_W-1:0] y;
  logic                            line_start;
  logic                            frame_start;

  modport master (
    output pix_en, h_count, v_count, hsync, vsync, active, x, y, line_start, frame_start
  );

  modport slave (
    input pix_en, h_count, v_count, hsync, vsync, active, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_pix_tick.sv
// rtl/vga_pix_tick.sv - system-clock divider producing the registered pixel-enable strobe
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_pix_tick: CLK_DIV must be at least 1");
    end
  endgenerate

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q, pix_en_d;

  // Registered strobe keeps pix_en low in reset even when CLK_DIV is 1
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d  = (div_cnt_q == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - horizontal/vertical counters with registered sync, window and coordinate decode
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga_o
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;

  localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_FIRST = cnt_t'(H_ACT_START);
  localparam cnt_t H_ACT_LAST  = cnt_t'(H_ACT_START + H_ACTIVE - 1);
  localparam cnt_t V_ACT_FIRST = cnt_t'(V_ACT_START);
  localparam cnt_t V_ACT_LAST  = cnt_t'(V_ACT_START + V_ACTIVE - 1);

  generate
    if (H_TOTAL > CNT_MAX) begin : g_h_too_long
      $error("vga_timing_gen: H_TOTAL exceeds the counter range");
    end
    if (V_TOTAL > CNT_MAX) begin : g_v_too_long
      $error("vga_timing_gen: V_TOTAL exceeds the counter range");
    end
  endgenerate

  logic        pix_en;
  cnt_t        h_q, h_d, v_q, v_d;
  logic        h_wrap, v_wrap;
  vga_decode_t dec_q, dec_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  vga_pix_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_en_o(pix_en)
  );

  // Decode runs on the next-state counters so outputs line up with h_q/v_q
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    line_start_d  = pix_en && h_wrap;
    frame_start_d = pix_en && h_wrap && v_wrap;
    dec_d.hsync   = (h_d >= H_SYNC_END);
    dec_d.vsync   = (v_d >= V_SYNC_END);
    dec_d.active  = (h_d >= H_ACT_FIRST) && (h_d <= H_ACT_LAST) &&
                    (v_d >= V_ACT_FIRST) && (v_d <= V_ACT_LAST);
    dec_d.x       = dec_d.active ? h_d - H_ACT_FIRST : '0;
    dec_d.y       = dec_d.active ? v_d - V_ACT_FIRST : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      dec_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      dec_q         <= dec_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.pix_en      = pix_en;
  assign vga_o.h_count     = h_q;
  assign vga_o.v_count     = v_q;
  assign vga_o.hsync       = dec_q.hsync;
  assign vga_o.vsync       = dec_q.vsync;
  assign vga_o.active      = dec_q.active;
  assign vga_o.x           = dec_q.x;
  assign vga_o.y           = dec_q.y;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a cycle-count reference model
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int d, hs, hbp, ha, hfp, vs, vbp, va, vfp;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if dif();
  vga_timing_if hif();
  vga_timing_if sif();

  vga_timing_gen u_def (
    .clk  (clk),
    .rst_n(rst_n),
    .vga_o(dif)
  );

  vga_timing_gen #(
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
  ) u_hor (
    .clk  (clk),
    .rst_n(rst_n),
    .vga_o(hif)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
  ) u_sml (
    .clk  (clk),
    .rst_n(rst_n),
    .vga_o(sif)
  );

  obs_t act_d, act_h, act_s;
  assign act_d = {dif.pix_en, dif.h_count, dif.v_count, dif.hsync, dif.vsync, dif.active,
                  dif.x, dif.y, dif.line_start, dif.frame_start};
  assign act_h = {hif.pix_en, hif.h_count, hif.v_count, hif.hsync, hif.vsync, hif.active,
                  hif.x, hif.y, hif.line_start, hif.frame_start};
  assign act_s = {sif.pix_en, sif.h_count, sif.v_count, sif.hsync, sif.vsync, sif.active,
                  sif.x, sif.y, sif.line_start, sif.frame_start};

  cfg_t c_d, c_h, c_s;
  obs_t q_d[$], q_h[$], q_s[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n = 0;
  int   rel = 0;
  logic meas = 1'b0;

  int first_pix = -1, d_ls = 0, d_ls0 = 0, d_lper = 0, d_hlow = 0;
  int h_fs = 0, h_fs0 = 0, h_fper = 0, h_act = 0, h_x0_at = -1, h_xl_at = -1;
  int s_fs = 0, s_fs0 = 0, s_fper = 0, s_act = 0, s_vlow = 0;

  // n = rising edges since reset was last sampled high; everything follows from it
  function automatic obs_t model(cfg_t c, int nn);
    obs_t e;
    int   ht, vt, p, h, v, hst, vst;
    logic step;
    ht   = c.hs + c.hbp + c.ha + c.hfp;
    vt   = c.vs + c.vbp + c.va + c.vfp;
    p    = (nn >= 1) ? (nn - 1) / c.d : 0;
    h    = p % ht;
    v    = (p / ht) % vt;
    hst  = c.hs + c.hbp;
    vst  = c.vs + c.vbp;
    step = (nn > c.d) && ((nn - 1) % c.d == 0);
    e.pix_en = (nn >= 1) && (nn % c.d == 0);
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.hsync  = (h >= c.hs);
    e.vsync  = (v >= c.vs);
    e.active = (h >= hst) && (h < hst + c.ha) && (v >= vst) && (v < vst + c.va);
    e.x      = e.active ? 10'(h - hst) : 10'd0;
    e.y      = e.active ? 10'(v - vst) : 10'd0;
    e.ls     = step && (h == 0);
    e.fs     = step && (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic cmp(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got pix=%b h=%0d v=%0d hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b want pix=%b h=%0d v=%0d hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b",
               nm, cyc, a.pix_en, a.h, a.v, a.hsync, a.vsync, a.active, a.x, a.y, a.ls, a.fs,
               e.pix_en, e.h, e.v, e.hsync, e.vsync, e.active, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    n = rst_n ? n + 1 : 0;
    q_d.push_back(model(c_d, n));
    q_h.push_back(model(c_h, n));
    q_s.push_back(model(c_s, n));
    #1;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k && errors <= 50; i++) tick();
  endtask

  task automatic measure();
    if (dif.pix_en && first_pix < 0) first_pix = cyc - rel;
    if (dif.line_start) begin
      d_ls++;
      if (d_ls == 1) d_ls0 = cyc;
      else if (d_ls == 2) d_lper = cyc - d_ls0;
    end
    if (d_ls == 1 && !dif.hsync) d_hlow++;
    if (hif.frame_start) begin
      h_fs++;
      if (h_fs == 1) h_fs0 = cyc;
      else if (h_fs == 2) h_fper = cyc - h_fs0;
    end
    if (h_fs == 1 && hif.active && hif.pix_en) begin
      h_act++;
      if (hif.x == 10'd0) h_x0_at = int'(hif.h_count);
      if (hif.x == 10'(DEF_H_ACTIVE - 1)) h_xl_at = int'(hif.h_count);
    end
    if (sif.frame_start) begin
      s_fs++;
      if (s_fs == 1) s_fs0 = cyc;
      else if (s_fs == 2) s_fper = cyc - s_fs0;
    end
    if (s_fs == 1 && sif.active && sif.pix_en) s_act++;
    if (s_fs == 1 && !sif.vsync) s_vlow++;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (q_d.size() > 0) cmp("def", act_d, q_d.pop_front());
      if (q_h.size() > 0) cmp("hor", act_h, q_h.pop_front());
      if (q_s.size() > 0) cmp("sml", act_s, q_s.pop_front());
      if (meas) measure();
    end
  endtask

  task automatic drive();
    rst_n = 1'b0;
    repeat (10) tick();
    rst_n = 1'b1;
    rel   = cyc;
    meas  = 1'b1;
    run(33000);
    meas  = 1'b0;
    chk_int("def_first_pix_en", first_pix, DEF_CLK_DIV);
    chk_int("def_line_period", d_lper, DEF_H_TOTAL * DEF_CLK_DIV);
    chk_int("def_hsync_low", d_hlow, DEF_H_SYNC * DEF_CLK_DIV);
    chk_int("hor_frame_period", h_fper, DEF_H_TOTAL * 5 * DEF_CLK_DIV);
    chk_int("hor_active_px", h_act, DEF_H_ACTIVE * 2);
    chk_int("hor_x0_at_h", h_x0_at, DEF_H_ACT_START);
    chk_int("hor_xlast_at_h", h_xl_at, DEF_H_ACT_START + DEF_H_ACTIVE - 1);
    chk_int("sml_frame_period", s_fper, 12 * 9);
    chk_int("sml_active_px", s_act, 5 * 4);
    chk_int("sml_vsync_low", s_vlow, 2 * 12);
    // Mid-frame resets of random length at random points
    for (int i = 0; i < 40 && errors <= 50; i++) begin
      run($urandom_range(600, 30));
      rst_n = 1'b0;
      run((i == 0) ? 1 : $urandom_range(3, 1));
      rst_n = 1'b1;
    end
    run(50);
    @(negedge clk);
    #1;
  endtask

  initial begin
    c_d = '{DEF_CLK_DIV, DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP,
            DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP};
    c_h = '{DEF_CLK_DIV, DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP, 1, 1, 2, 1};
    c_s = '{1, 3, 2, 5, 2, 2, 2, 4, 1};
    fork
      drive();
      monitor_loop();
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
